regfile_sb: RTL

Parametrised register file with write-first bypass, optional hardwired-zero register, selectable combinational or registered read, and a per-register busy scoreboard. Generalises the fixed 8x8 two-read/one-write `regd` for the datapath. Decode marks destinations pending at issue, writeback clears them, and operand fetch uses the busy outputs to stall.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_busy_sb.sv | 46 ++++
 rtl/regfile_sb.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, read-mode encodings and the address-validity helper for regfile_sb.
package regfile_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        RD_COMB = 1'b0,
        RD_REG  = 1'b1
    } rd_mode_e;

    // A register index is usable when it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input int a, input int depth, input int zero_reg);
        return (a < depth) && !((zero_reg != 0) && (a == 0));
    endfunction

endpackage

// File: rtl/regfile_busy_sb.sv
// Per-register pending-write scoreboard: issue sets, writeback clears, set wins on a tie.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             clr_ok;
    logic             set_ok;

    assign clr_ok = clr_en && addr_ok(int'(clr_addr), DEPTH, ZERO_REG);
    assign set_ok = set_en && addr_ok(int'(set_addr), DEPTH, ZERO_REG);

    // NOTE: give every always_comb output a default first, or a missed path infers a latch.
    always_comb begin
        busy_d = busy_q;
        if (clr_ok) busy_d[clr_addr] = 1'b0;
        if (set_ok) busy_d[set_addr] = 1'b1;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // A writeback landing this cycle satisfies the reader through the data bypass.
    assign busy1 = addr_ok(int'(ra1), DEPTH, ZERO_REG) && busy_q[ra1] && !(clr_en && clr_addr == ra1);
    assign busy2 = addr_ok(int'(ra2), DEPTH, ZERO_REG) && busy_q[ra2] && !(clr_en && clr_addr == ra2);

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-first bypass, optional zero register,
// optional registered read and a busy scoreboard for operand-fetch stalls.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  ZERO_REG = 1,
    parameter int  READ_REG = int'(RD_COMB),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwrite,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rv1_d;
    logic [WIDTH-1:0] rv2_d;
    logic             wr_ok;

    assign wr_ok = regwrite && addr_ok(int'(wa), DEPTH, ZERO_REG);

    // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wa] <= wd;
        end
    end

    always_comb begin
        rv1_d = '0;
        rv2_d = '0;
        if (addr_ok(int'(ra1), DEPTH, ZERO_REG)) rv1_d = (regwrite && wa == ra1) ? wd : mem_q[ra1];
        if (addr_ok(int'(ra2), DEPTH, ZERO_REG)) rv2_d = (regwrite && wa == ra2) ? wd : mem_q[ra2];
    end

    if (READ_REG == int'(RD_REG)) begin : g_rd_reg
        logic [WIDTH-1:0] rd1_q;
        logic [WIDTH-1:0] rd2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= rv1_d;
                rd2_q <= rv2_d;
            end
        end

        assign rd1 = rd1_q;
        assign rd2 = rd2_q;
    end else begin : g_rd_comb
        assign rd1 = rv1_d;
        assign rd2 = rv2_d;
    end

    regfile_busy_sb #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (regwrite),
        .clr_addr (wa),
        .set_en   (busy_set),
        .set_addr (busy_addr),
        .ra1      (ra1),
        .ra2      (ra2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule
